// File: rtl/empty_addr_pool_if.sv
// Handshake bundle between the free-address pool and its insert/delete clients.
// The pool is the slave end; the engines together form the master end.
interface empty_addr_pool_if #(
   parameter int A_WIDTH = 3
) ();
   logic [A_WIDTH-1:0] empty_addr;
   logic               empty_addr_val;
   logic               empty_addr_rd_ack;
   logic [A_WIDTH-1:0] free_addr;
   logic               free_addr_val;

   modport master (
      input  empty_addr,
      input  empty_addr_val,
      output empty_addr_rd_ack,
      output free_addr,
      output free_addr_val
   );

   modport slave (
      output empty_addr,
      output empty_addr_val,
      input  empty_addr_rd_ack,
      input  free_addr,
      input  free_addr_val
   );
endinterface

// File: rtl/empty_addr_pool.sv
// Free-address pool: self-loads every table address after reset, then serves
// them as a show-ahead FIFO and accepts addresses returned by the delete engine.
module empty_addr_pool #(
   parameter int TABLE_ADDR_WIDTH = 3,
   parameter int A_WIDTH          = TABLE_ADDR_WIDTH,
   parameter int DEPTH            = 2**A_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   empty_addr_pool_if.slave   eif,
   output logic [A_WIDTH:0]   free_cnt_o,
   output logic               init_done_o,
   output logic               err_overflow_o,
   output logic               err_underflow_o
);
   localparam int                 CW     = A_WIDTH + 1;
   localparam logic [A_WIDTH:0]   FULL_C = CW'(DEPTH);
   localparam logic [A_WIDTH-1:0] LAST_C = A_WIDTH'(DEPTH - 1);

   typedef enum logic [0:0] {INIT_S = 1'b0, RUN_S = 1'b1} state_t;

   state_t             state_q;
   logic [A_WIDTH-1:0] mem_q [DEPTH];
   logic [A_WIDTH-1:0] rd_ptr_q;
   logic [A_WIDTH-1:0] wr_ptr_q;
   logic [A_WIDTH-1:0] init_cnt_q;
   logic [A_WIDTH:0]   cnt_q;
   logic               val_q;
   logic               done_q;
   logic               ovf_q;
   logic               udf_q;

   logic               pop_s;
   logic               push_s;
   logic [A_WIDTH:0]   cnt_d;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [A_WIDTH-1:0] next_ptr(input logic [A_WIDTH-1:0] p);
      if (p == LAST_C) begin
         return '0;
      end else begin
         return p + A_WIDTH'(1);
      end
   endfunction

   // Accept decisions; a concurrent pop frees the slot a push into a full pool needs.
   always_comb begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      cnt_d  = cnt_q;
      if (state_q == RUN_S) begin
         pop_s  = eif.empty_addr_rd_ack && val_q;
         push_s = eif.free_addr_val && ((cnt_q != FULL_C) || pop_s);
         cnt_d  = cnt_q + CW'(push_s) - CW'(pop_s);
      end else begin
         pop_s  = 1'b0;
         push_s = 1'b0;
         cnt_d  = cnt_q;
      end
   end

   // Init sequencer, FIFO state and sticky error flags.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= INIT_S;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         init_cnt_q <= '0;
         cnt_q      <= '0;
         val_q      <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            INIT_S: begin
               mem_q[init_cnt_q] <= init_cnt_q;
               if (init_cnt_q == LAST_C) begin
                  state_q    <= RUN_S;
                  init_cnt_q <= '0;
                  cnt_q      <= FULL_C;
                  val_q      <= 1'b1;
                  done_q     <= 1'b1;
               end else begin
                  init_cnt_q <= init_cnt_q + A_WIDTH'(1);
               end
            end
            RUN_S: begin
               if (push_s) begin
                  mem_q[wr_ptr_q] <= eif.free_addr;
                  wr_ptr_q        <= next_ptr(wr_ptr_q);
               end
               if (pop_s) begin
                  rd_ptr_q <= next_ptr(rd_ptr_q);
               end
               cnt_q <= cnt_d;
               val_q <= (cnt_d != '0);
            end
            default: begin
               state_q <= INIT_S;
            end
         endcase
         if (eif.free_addr_val && !push_s) begin
            ovf_q <= 1'b1;
         end
         if (eif.empty_addr_rd_ack && !pop_s) begin
            udf_q <= 1'b1;
         end
      end
   end

   assign eif.empty_addr     = mem_q[rd_ptr_q];
   assign eif.empty_addr_val = val_q;
   assign free_cnt_o         = cnt_q;
   assign init_done_o        = done_q;
   assign err_overflow_o     = ovf_q;
   assign err_underflow_o    = udf_q;
endmodule

// File: tb/tb_empty_addr_pool.sv
// Directed bench for empty_addr_pool with A_WIDTH=3 (eight addresses).
module tb_empty_addr_pool;
   logic       clk;
   logic       rst_n;
   logic [3:0] free_cnt;
   logic       init_done;
   logic       err_ovf;
   logic       err_udf;
   int         checks;
   int         errors;

   empty_addr_pool_if #(.A_WIDTH(3)) eif ();

   empty_addr_pool #(.A_WIDTH(3)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .eif             (eif),
      .free_cnt_o      (free_cnt),
      .init_done_o     (init_done),
      .err_overflow_o  (err_ovf),
      .err_underflow_o (err_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_val"},  32'(eif.empty_addr_val), 32'd0);
      chk({tag, "_addr"}, 32'(eif.empty_addr),     32'd0);
      chk({tag, "_cnt"},  32'(free_cnt),           32'd0);
      chk({tag, "_done"}, 32'(init_done),          32'd0);
      chk({tag, "_ovf"},  32'(err_ovf),            32'd0);
      chk({tag, "_udf"},  32'(err_udf),            32'd0);
   endtask

   task automatic init_seq(input string tag);
      for (int k = 1; k < 8; k++) begin
         step();
         chk({tag, "_busy_val"},  32'(eif.empty_addr_val), 32'd0);
         chk({tag, "_busy_done"}, 32'(init_done),          32'd0);
         chk({tag, "_busy_cnt"},  32'(free_cnt),           32'd0);
      end
      step();
      chk({tag, "_end_val"},  32'(eif.empty_addr_val), 32'd1);
      chk({tag, "_end_addr"}, 32'(eif.empty_addr),     32'd0);
      chk({tag, "_end_cnt"},  32'(free_cnt),           32'd8);
      chk({tag, "_end_done"}, 32'(init_done),          32'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      eif.empty_addr_rd_ack = 1'b0;
      eif.free_addr_val     = 1'b0;
      eif.free_addr         = 3'd0;
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      init_seq("init");

      // Drain all eight addresses back to back.
      eif.empty_addr_rd_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_val",  32'(eif.empty_addr_val), 32'd1);
         chk("drain_addr", 32'(eif.empty_addr),     32'(i));
         step();
      end
      eif.empty_addr_rd_ack = 1'b0;
      chk("drained_val", 32'(eif.empty_addr_val), 32'd0);
      chk("drained_cnt", 32'(free_cnt),           32'd0);
      chk("drained_udf", 32'(err_udf),            32'd0);
      eif.empty_addr_rd_ack = 1'b1;
      step();
      eif.empty_addr_rd_ack = 1'b0;
      chk("underflow_flag", 32'(err_udf),  32'd1);
      chk("underflow_cnt",  32'(free_cnt), 32'd0);

      // Recycle from empty.
      eif.free_addr_val = 1'b1;
      eif.free_addr     = 3'd5;
      step();
      chk("push5_val",  32'(eif.empty_addr_val), 32'd1);
      chk("push5_addr", 32'(eif.empty_addr),     32'd5);
      chk("push5_cnt",  32'(free_cnt),           32'd1);
      eif.free_addr = 3'd2;
      step();
      eif.free_addr_val = 1'b0;
      chk("push2_cnt",  32'(free_cnt),       32'd2);
      chk("push2_addr", 32'(eif.empty_addr), 32'd5);
      eif.empty_addr_rd_ack = 1'b1;
      step();
      chk("pop5_addr", 32'(eif.empty_addr),     32'd2);
      chk("pop5_val",  32'(eif.empty_addr_val), 32'd1);
      step();
      eif.empty_addr_rd_ack = 1'b0;
      chk("pop2_val", 32'(eif.empty_addr_val), 32'd0);
      chk("pop2_cnt", 32'(free_cnt),           32'd0);

      // Simultaneous pop and push at count 1, then at count 0.
      eif.free_addr_val = 1'b1;
      eif.free_addr     = 3'd3;
      step();
      chk("push3_addr", 32'(eif.empty_addr), 32'd3);
      chk("push3_cnt",  32'(free_cnt),       32'd1);
      eif.empty_addr_rd_ack = 1'b1;
      eif.free_addr         = 3'd6;
      step();
      eif.free_addr_val = 1'b0;
      chk("swap1_cnt",  32'(free_cnt),           32'd1);
      chk("swap1_addr", 32'(eif.empty_addr),     32'd6);
      chk("swap1_val",  32'(eif.empty_addr_val), 32'd1);
      step();
      chk("pop6_val", 32'(eif.empty_addr_val), 32'd0);
      eif.free_addr_val = 1'b1;
      eif.free_addr     = 3'd7;
      step();
      eif.free_addr_val     = 1'b0;
      eif.empty_addr_rd_ack = 1'b0;
      chk("swap0_cnt",  32'(free_cnt),       32'd1);
      chk("swap0_addr", 32'(eif.empty_addr), 32'd7);
      chk("swap0_ovf",  32'(err_ovf),        32'd0);

      // Asynchronous reset away from the clock edge.
      #2 rst_n = 1'b0;
      #1 chk_zero("rst1");
      @(negedge clk);
      rst_n = 1'b1;
      init_seq("reinit");
      chk("reinit_udf", 32'(err_udf), 32'd0);

      // Pop and push together while full: accepted, no overflow.
      eif.empty_addr_rd_ack = 1'b1;
      eif.free_addr_val     = 1'b1;
      eif.free_addr         = 3'd4;
      step();
      eif.empty_addr_rd_ack = 1'b0;
      chk("swapfull_cnt",  32'(free_cnt),       32'd8);
      chk("swapfull_ovf",  32'(err_ovf),        32'd0);
      chk("swapfull_addr", 32'(eif.empty_addr), 32'd1);
      eif.free_addr = 3'd1;
      step();
      eif.free_addr_val = 1'b0;
      chk("overflow_flag", 32'(err_ovf),        32'd1);
      chk("overflow_cnt",  32'(free_cnt),       32'd8);
      chk("overflow_addr", 32'(eif.empty_addr), 32'd1);

      // Pop three, then reset mid-run with misuse during the following init.
      eif.empty_addr_rd_ack = 1'b1;
      step();
      step();
      step();
      eif.empty_addr_rd_ack = 1'b0;
      chk("pop3_addr", 32'(eif.empty_addr), 32'd4);
      chk("pop3_cnt",  32'(free_cnt),       32'd5);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         eif.free_addr_val     = (k == 3);
         eif.free_addr         = 3'd2;
         eif.empty_addr_rd_ack = (k == 5);
         step();
         eif.free_addr_val     = 1'b0;
         eif.empty_addr_rd_ack = 1'b0;
         if (k < 8) begin
            chk("misuse_val", 32'(eif.empty_addr_val), 32'd0);
            chk("misuse_ovf", 32'(err_ovf), (k >= 3) ? 32'd1 : 32'd0);
            chk("misuse_udf", 32'(err_udf), (k >= 5) ? 32'd1 : 32'd0);
         end
      end
      chk("misuse_end_val",  32'(eif.empty_addr_val), 32'd1);
      chk("misuse_end_addr", 32'(eif.empty_addr),     32'd0);
      chk("misuse_end_cnt",  32'(free_cnt),           32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
